operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Reader side of the integer register file: decode -> execute stage of the RV32I core.
//  Drives the register file read addresses and captures rs1/rs2 operands into a 1-entry output register.
//  Holds a per-register pending-write scoreboard; stalls RAW/WAW hazards until writeback clears the bit.
//  Snoops the writeback port (same signals that drive the register file write port).
// PARAMETERS
//  REG_SIZE   32  data width of one architectural register
//  REG_WIDTH  5   register address width (2**REG_WIDTH registers, x0 hardwired zero)
//  TAG_WIDTH  32  width of opaque sideband (PC/opcode) passed through unchanged
// PORTS
//  clk           in   1          clock, all state on rising edge
//  reset         in   1          synchronous, active-high reset
//  in_valid      in   1          decoded instruction present
//  in_ready      out  1          stage accepts instruction this cycle
//  in_rs1_addr   in   REG_WIDTH  source 1 index
//  in_rs2_addr   in   REG_WIDTH  source 2 index
//  in_uses_rs1   in   1          instruction reads rs1
//  in_uses_rs2   in   1          instruction reads rs2
//  in_rd_addr    in   REG_WIDTH  destination index
//  in_rd_write   in   1          instruction writes rd
//  in_tag        in   TAG_WIDTH  sideband
//  rs1_addr      out  REG_WIDTH  to register file read port 1 (= in_rs1_addr, combinational)
//  rs2_addr      out  REG_WIDTH  to register file read port 2 (= in_rs2_addr, combinational)
//  rs1_read      in   REG_SIZE   register file combinational read data 1
//  rs2_read      in   REG_SIZE   register file combinational read data 2
//  wb_enable     in   1          writeback write strobe
//  wb_addr       in   REG_WIDTH  writeback destination
//  wb_data       in   REG_SIZE   writeback data
//  out_valid     out  1          operands valid
//  out_ready     in   1          execute accepts
//  out_rs1_data  out  REG_SIZE   operand 1
//  out_rs2_data  out  REG_SIZE   operand 2
//  out_rd_addr   out  REG_WIDTH  destination index
//  out_rd_write  out  1          destination write flag
//  out_tag       out  TAG_WIDTH  sideband
// BEHAVIOUR
//  - Reset (clk edge with reset=1): out_valid=0, all out_* data/addr/tag=0, pending[*]=0; in_ready=0 while reset=1.
//  - clr[r] = wb_enable && wb_addr==r && r!=0. Scoreboard set: accept && in_rd_write && in_rd_addr!=0.
//  - Same-cycle set and clear of same index: set wins (pending=1). Pending bit for x0 is never set.
//  - raw1 = in_uses_rs1 && pending[rs1] && !(BYPASS && clr[rs1]); raw2 likewise for rs2.
//  - waw = in_rd_write && in_rd_addr!=0 && pending[rd] && !clr[rd] (same in both configurations).
//  - in_ready = !reset && (!out_valid || out_ready) && !raw1 && !raw2 && !waw; accept = in_valid && in_ready.
//  - On accept: output register loads all fields, out_valid=1 next cycle (latency 1 cycle).
//  - Operand select: index 0 -> 0 regardless of rs*_read; else bypass hit -> wb_data; else rs*_read.
//  - out_valid && out_ready && !accept -> out_valid=0. Data fields hold while out_valid && !out_ready.
//  - in_valid=0 or stall: output register untouched except out_valid drop above; no scoreboard set.
//  - Scoreboard clears on wb even for indices not set (no error); at most one write in flight per register.
//  - Reset mid-operation discards the held instruction and all pending bits; caller must flush downstream.
// CONFIGURATION
//  SCOREBOARD_BYPASS_EN defined: wb of a pending source in the same cycle resolves RAW;
//    operand taken from wb_data (file not yet updated). Zero stall cycles after writeback.
//  Not defined: RAW stalls while pending bit is set; accept earliest the cycle after wb;
//    operand always from rs*_read. One extra stall cycle per RAW dependency. WAW rule unchanged.
// TESTING
//  1 Reset: reset=1 two cycles -> out_valid=0, outs 0, in_ready=0; reset=0, out_ready=1 -> in_ready=1.
//  2 rs1=1,rs2=2, file drives 0x11/0x22, accept -> next cycle out_valid=1, data 0x11/0x22, tag passed.
//  3 Issue rd=5 write; next rs1=5 stalls (in_ready=0) 3 cycles; wb 5<=0xDEAD ->
//    BYPASS_EN: accepted that cycle, out_rs1_data=0xDEAD; without: accepted next cycle from file.
//  4 rd=0 write accepted -> no pending; then rs1=0 with rs1_read=0xFFFF -> no stall, out_rs1_data=0.
//  5 out_ready=0 with out_valid=1 -> in_ready=0, all out_* stable 4 cycles; out_ready=1 -> drains.
//  6 pending[7]=1, wb 7 same cycle new instr rd=7 accepted -> pending[7] stays 1; next rs1=7 stalls.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Decode -> operand-fetch -> execute handshake bundle for operand_fetch.
// master = surrounding pipeline (drives in_*, consumes out_*), slave = operand_fetch.
interface operand_fetch_if #(
  parameter int REG_SIZE  = 32,
  parameter int REG_WIDTH = 5,
  parameter int TAG_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [REG_WIDTH-1:0] in_rs1_addr;
  logic [REG_WIDTH-1:0] in_rs2_addr;
  logic                 in_uses_rs1;
  logic                 in_uses_rs2;
  logic [REG_WIDTH-1:0] in_rd_addr;
  logic                 in_rd_write;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [REG_SIZE-1:0]  out_rs1_data;
  logic [REG_SIZE-1:0]  out_rs2_data;
  logic [REG_WIDTH-1:0] out_rd_addr;
  logic                 out_rd_write;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_uses_rs1, in_uses_rs2,
           in_rd_addr, in_rd_write, in_tag, out_ready,
    input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_addr,
           out_rd_write, out_tag
  );

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_uses_rs1, in_uses_rs2,
           in_rd_addr, in_rd_write, in_tag, out_ready,
    output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_addr,
           out_rd_write, out_tag
  );
endinterface

// File: rtl/operand_fetch.sv
// RV32I operand fetch: register file read, pending-write scoreboard, 1-entry output register.
// Define SCOREBOARD_BYPASS_EN to resolve RAW hazards from the writeback port in the same cycle.
module operand_fetch #(
  parameter int REG_SIZE  = 32,
  parameter int REG_WIDTH = 5,
  parameter int TAG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  operand_fetch_if.slave       pipe,
  output logic [REG_WIDTH-1:0] rs1_addr,
  output logic [REG_WIDTH-1:0] rs2_addr,
  input  logic [REG_SIZE-1:0]  rs1_read,
  input  logic [REG_SIZE-1:0]  rs2_read,
  input  logic                 wb_enable,
  input  logic [REG_WIDTH-1:0] wb_addr,
  input  logic [REG_SIZE-1:0]  wb_data
);

  localparam int NUM_REGS = 2 ** REG_WIDTH;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;
  logic                byp1, byp2;
  logic                raw1, raw2, waw;
  logic                accept;
  logic [REG_SIZE-1:0] op1, op2;

  assign rs1_addr = pipe.in_rs1_addr;
  assign rs2_addr = pipe.in_rs2_addr;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    clr = '0;
    if (wb_enable && wb_addr != '0)
      clr[wb_addr] = 1'b1;
  end

`ifdef SCOREBOARD_BYPASS_EN
  assign byp1 = clr[pipe.in_rs1_addr];
  assign byp2 = clr[pipe.in_rs2_addr];
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign raw1 = pipe.in_uses_rs1 && pending[pipe.in_rs1_addr] && !byp1;
  assign raw2 = pipe.in_uses_rs2 && pending[pipe.in_rs2_addr] && !byp2;
  // A writeback retiring rd this cycle frees the slot for the next writer of rd.
  assign waw  = pipe.in_rd_write && pipe.in_rd_addr != '0 &&
                pending[pipe.in_rd_addr] && !clr[pipe.in_rd_addr];

  assign pipe.in_ready = !reset && (!pipe.out_valid || pipe.out_ready) &&
                         !raw1 && !raw2 && !waw;
  assign accept = pipe.in_valid && pipe.in_ready;

  always_comb begin
    set = '0;
    if (accept && pipe.in_rd_write && pipe.in_rd_addr != '0)
      set[pipe.in_rd_addr] = 1'b1;
  end

  // x0 reads as zero; a same-cycle writeback hit beats the not-yet-updated file.
  always_comb begin
    if (pipe.in_rs1_addr == '0) op1 = '0;
    else if (byp1)              op1 = wb_data;
    else                        op1 = rs1_read;
    if (pipe.in_rs2_addr == '0) op2 = '0;
    else if (byp2)              op2 = wb_data;
    else                        op2 = rs2_read;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      // Set is OR-ed after the clear, so a same-cycle set wins.
      pending <= (pending & ~clr) | set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe.out_valid    <= 1'b0;
      pipe.out_rs1_data <= '0;
      pipe.out_rs2_data <= '0;
      pipe.out_rd_addr  <= '0;
      pipe.out_rd_write <= 1'b0;
      pipe.out_tag      <= '0;
    end else if (accept) begin
      pipe.out_valid    <= 1'b1;
      pipe.out_rs1_data <= op1;
      pipe.out_rs2_data <= op2;
      pipe.out_rd_addr  <= pipe.in_rd_addr;
      pipe.out_rd_write <= pipe.in_rd_write;
      pipe.out_tag      <= pipe.in_tag;
    end else if (pipe.out_valid && pipe.out_ready) begin
      pipe.out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hand-written hazard/backpressure sequences.
// Expectations follow SCOREBOARD_BYPASS_EN when the bench is built with it.
module tb_operand_fetch;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_read, rs2_read;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;

  operand_fetch_if #(.REG_SIZE(32), .REG_WIDTH(5), .TAG_WIDTH(32)) pipe ();

  operand_fetch #(.REG_SIZE(32), .REG_WIDTH(5), .TAG_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe      (pipe),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_read  (rs1_read),
    .rs2_read  (rs2_read),
    .wb_enable (wb_enable),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment; x0 deliberately holds garbage to prove it is ignored.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
      rf[0] <= 32'hFFFF;
      rf[1] <= 32'h11;
      rf[2] <= 32'h22;
    end else if (wb_enable && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end
  assign rs1_read = rf[rs1_addr];
  assign rs2_read = rf[rs2_addr];

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] tag;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_ready;
    logic [31:0] exp1, exp2;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rdw, input logic [31:0] tag);
    pipe.in_valid    = v;
    pipe.in_rs1_addr = r1;
    pipe.in_rs2_addr = r2;
    pipe.in_uses_rs1 = u1;
    pipe.in_uses_rs2 = u2;
    pipe.in_rd_addr  = rd;
    pipe.in_rd_write = rdw;
    pipe.in_tag      = tag;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_enable = en;
    wb_addr   = a;
    wb_data   = d;
  endtask

  // Inputs change #1 after posedge; combinational outputs are sampled at the negedge.
  task automatic to_negedge();
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pipe.out_ready = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 32'h1);
    set_wb(1'b0, 5'd0, 32'h0);

    // Reset: two cycles, in_ready low and output register cleared.
    tick();
    to_negedge();
    check("reset in_ready", {31'd0, pipe.in_ready}, 32'd0);
    tick();
    check("reset out_valid", {31'd0, pipe.out_valid}, 32'd0);
    check("reset out_rs1",   pipe.out_rs1_data, 32'd0);
    check("reset out_rs2",   pipe.out_rs2_data, 32'd0);
    check("reset out_rd",    {27'd0, pipe.out_rd_addr}, 32'd0);
    check("reset out_rdw",   {31'd0, pipe.out_rd_write}, 32'd0);
    check("reset out_tag",   pipe.out_tag, 32'd0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    to_negedge();
    check("post-reset in_ready", {31'd0, pipe.in_ready}, 32'd1);
    tick();

    // valid rs1 rs2 u1 u2 rd rdw tag | wb_en wb_addr wb_data | ready exp1 exp2
    vecs[0]  = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b0, 32'hCAFE0001, 1'b0, 5'd0,  32'h0,    1'b1, 32'h11,   32'h22};
    vecs[1]  = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 32'hCAFE0002, 1'b0, 5'd0,  32'h0,    1'b1, 32'h0,    32'h0};
    vecs[2]  = '{1'b1, 5'd0,  5'd3,  1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE0003, 1'b0, 5'd0,  32'h0,    1'b1, 32'h0,    32'h103};
    vecs[3]  = '{1'b1, 5'd4,  5'd5,  1'b0, 1'b0, 5'd11, 1'b0, 32'hCAFE0004, 1'b0, 5'd0,  32'h0,    1'b1, 32'h104,  32'h105};
    vecs[4]  = '{1'b0, 5'd1,  5'd2,  1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE0005, 1'b0, 5'd0,  32'h0,    1'b1, 32'h11,   32'h22};
    vecs[5]  = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd9,  1'b1, 32'hCAFE0006, 1'b0, 5'd0,  32'h0,    1'b1, 32'h11,   32'h22};
    vecs[6]  = '{1'b1, 5'd9,  5'd2,  1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE0007, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,    32'h0};
    vecs[7]  = '{1'b1, 5'd1,  5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 32'hCAFE0008, 1'b0, 5'd0,  32'h0,    1'b1, 32'h11,   32'h109};
    vecs[8]  = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd9,  1'b1, 32'hCAFE0009, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,    32'h0};
    vecs[9]  = '{1'b1, 5'd9,  5'd2,  1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE000A, 1'b1, 5'd9,  32'h9999, BYP,  32'h9999, 32'h22};
    vecs[10] = '{1'b1, 5'd9,  5'd2,  1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE000B, 1'b0, 5'd0,  32'h0,    1'b1, 32'h9999, 32'h22};
    vecs[11] = '{1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE000C, 1'b1, 5'd12, 32'h1212, 1'b1,
                 BYP ? 32'h1212 : 32'h10C, BYP ? 32'h1212 : 32'h10C};
    vecs[12] = '{1'b1, 5'd12, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE000D, 1'b0, 5'd0,  32'h0,    1'b1, 32'h1212, 32'h0};
    vecs[13] = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd10, 1'b1, 32'hCAFE000E, 1'b0, 5'd0,  32'h0,    1'b1, 32'h0,    32'h0};
    vecs[14] = '{1'b1, 5'd1,  5'd10, 1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE000F, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,    32'h0};
    vecs[15] = '{1'b1, 5'd1,  5'd10, 1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE0010, 1'b1, 5'd10, 32'hA0A0, BYP,  32'h11,   32'hA0A0};
    vecs[16] = '{1'b1, 5'd1,  5'd10, 1'b1, 1'b1, 5'd0,  1'b0, 32'hCAFE0011, 1'b0, 5'd0,  32'h0,    1'b1, 32'h11,   32'hA0A0};

    for (int i = 0; i < 17; i++) begin
      logic exp_v;
      drive(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rd, vecs[i].rdw, vecs[i].tag);
      set_wb(vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
      to_negedge();
      check($sformatf("v%0d in_ready", i), {31'd0, pipe.in_ready}, {31'd0, vecs[i].exp_ready});
      check($sformatf("v%0d rs1_addr", i), {27'd0, rs1_addr}, {27'd0, vecs[i].rs1});
      tick();
      exp_v = vecs[i].valid && vecs[i].exp_ready;
      check($sformatf("v%0d out_valid", i), {31'd0, pipe.out_valid}, {31'd0, exp_v});
      if (exp_v) begin
        check($sformatf("v%0d out_rs1", i), pipe.out_rs1_data, vecs[i].exp1);
        check($sformatf("v%0d out_rs2", i), pipe.out_rs2_data, vecs[i].exp2);
        check($sformatf("v%0d out_rd", i),  {27'd0, pipe.out_rd_addr}, {27'd0, vecs[i].rd});
        check($sformatf("v%0d out_rdw", i), {31'd0, pipe.out_rd_write}, {31'd0, vecs[i].rdw});
        check($sformatf("v%0d out_tag", i), pipe.out_tag, vecs[i].tag);
      end
    end
    set_wb(1'b0, 5'd0, 32'h0);

    // RAW on rd=5: three stall cycles, then resolved by writeback.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 32'h300);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h301);
    for (int c = 0; c < 3; c++) begin
      to_negedge();
      check($sformatf("raw5 stall %0d", c), {31'd0, pipe.in_ready}, 32'd0);
      tick();
    end
    check("raw5 out_valid dropped", {31'd0, pipe.out_valid}, 32'd0);
    set_wb(1'b1, 5'd5, 32'hDEAD);
    to_negedge();
    check("raw5 wb-cycle ready", {31'd0, pipe.in_ready}, {31'd0, BYP});
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
`ifdef SCOREBOARD_BYPASS_EN
    check("raw5 bypass valid", {31'd0, pipe.out_valid}, 32'd1);
    check("raw5 bypass data",  pipe.out_rs1_data, 32'hDEAD);
`else
    check("raw5 stall valid", {31'd0, pipe.out_valid}, 32'd0);
    to_negedge();
    check("raw5 after-wb ready", {31'd0, pipe.in_ready}, 32'd1);
    tick();
    check("raw5 file valid", {31'd0, pipe.out_valid}, 32'd1);
    check("raw5 file data",  pipe.out_rs1_data, 32'hDEAD);
`endif

    // Backpressure: output register held for four cycles, then drains.
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 32'h55);
    tick();
    pipe.out_ready = 1'b0;
    drive(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 32'h66);
    for (int c = 0; c < 4; c++) begin
      to_negedge();
      check($sformatf("hold %0d in_ready", c), {31'd0, pipe.in_ready}, 32'd0);
      tick();
      check($sformatf("hold %0d out_valid", c), {31'd0, pipe.out_valid}, 32'd1);
      check($sformatf("hold %0d out_rs1", c), pipe.out_rs1_data, 32'h11);
      check($sformatf("hold %0d out_tag", c), pipe.out_tag, 32'h55);
    end
    pipe.out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    to_negedge();
    check("drain in_ready", {31'd0, pipe.in_ready}, 32'd1);
    tick();
    check("drain out_valid", {31'd0, pipe.out_valid}, 32'd0);

    // Same-cycle set and clear of x7: set wins.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 32'h700);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 32'h701);
    set_wb(1'b1, 5'd7, 32'h77);
    to_negedge();
    check("x7 waw cleared ready", {31'd0, pipe.in_ready}, 32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h702);
    to_negedge();
    check("x7 still pending", {31'd0, pipe.in_ready}, 32'd0);
    tick();
    set_wb(1'b1, 5'd7, 32'h78);
    to_negedge();
    check("x7 wb-cycle ready", {31'd0, pipe.in_ready}, {31'd0, BYP});
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    to_negedge();
    check("x7 released ready", {31'd0, pipe.in_ready}, 32'd1);
    tick();
    check("x7 operand", pipe.out_rs1_data, 32'h78);

    // Reset mid-operation drops pending bits and the held instruction.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 32'h800);
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    check("midreset out_valid", {31'd0, pipe.out_valid}, 32'd0);
    check("midreset out_rd", {27'd0, pipe.out_rd_addr}, 32'd0);
    reset = 1'b0;
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h801);
    to_negedge();
    check("midreset x8 not pending", {31'd0, pipe.in_ready}, 32'd1);
    tick();
    check("midreset x8 operand", pipe.out_rs1_data, 32'h108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
